mem_port_arbiter: RTL and testbench

Shares one single-ported unified memory between the RV32 core's instruction-fetch (IF) port and its load/store (LS) port. Each requester uses a req/gnt/rvalid handshake. The block runs one memory transaction at a time on a req/ready/rvalid memory bus and returns read data to the owner. It sits between the core datapath and the memory model, under the top-level processor module.

---
 rtl/mem_port_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the IF and LS requesters, one transaction at a time.
// Define ARB_RR_EN for round-robin arbitration; the default build uses fixed LS-over-IF priority.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                ls_req,
    input  logic                ls_we,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_wstrb,
    output logic                ls_gnt,
    output logic                ls_rvalid,
    output logic [DATA_W-1:0]   ls_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_ready,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy,
    output logic                proto_err
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } mem_cmd_t;

    state_e      state_q, state_d;
    mem_cmd_t    cmd_q, cmd_d;
    logic        owner_ls_q, owner_ls_d;
    logic        if_gnt_q, if_gnt_d;
    logic        ls_gnt_q, ls_gnt_d;
    logic        if_rvalid_q, if_rvalid_d;
    logic        ls_rvalid_q, ls_rvalid_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
    logic        proto_err_q, proto_err_d;
    logic        any_req;
    logic        pick_ls;
    logic        grant;

    assign any_req = if_req | ls_req;
    assign grant   = (state_q == IDLE) && any_req;

`ifdef ARB_RR_EN
    // Remembers the last granted port; resets to IF so the first contention goes to LS.
    logic last_ls_q, last_ls_d;

    always_comb begin
        pick_ls = ls_req && (!if_req || !last_ls_q);
    end

    always_comb begin
        last_ls_d = last_ls_q;
        if (grant) last_ls_d = pick_ls;
    end

    always_ff @(posedge clk) begin
        if (reset) last_ls_q <= 1'b0;
        else       last_ls_q <= last_ls_d;
    end
`else
    always_comb begin
        pick_ls = ls_req;
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = ISSUE;
            ISSUE:   if (mem_ready) state_d = cmd_q.we ? IDLE : WAIT;
            WAIT:    if (mem_rvalid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from state
    always_comb begin
        mem_req = (state_q == ISSUE);
        busy    = (state_q != IDLE);
    end

    // Holding register, grant pulses and response registers
    always_comb begin
        cmd_d       = cmd_q;
        owner_ls_d  = owner_ls_q;
        if_gnt_d    = 1'b0;
        ls_gnt_d    = 1'b0;
        if_rvalid_d = 1'b0;
        ls_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        ls_rdata_d  = ls_rdata_q;
        proto_err_d = proto_err_q | (mem_rvalid && (state_q != WAIT));

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    owner_ls_d = pick_ls;
                    if (pick_ls) begin
                        ls_gnt_d    = 1'b1;
                        cmd_d.we    = ls_we;
                        cmd_d.addr  = ls_addr;
                        cmd_d.wdata = ls_we ? ls_wdata : '0;
                        cmd_d.wstrb = ls_we ? ls_wstrb : '0;
                    end else begin
                        if_gnt_d    = 1'b1;
                        cmd_d.we    = 1'b0;
                        cmd_d.addr  = if_addr;
                        cmd_d.wdata = '0;
                        cmd_d.wstrb = '0;
                    end
                end
            end
            ISSUE: begin
                // Only LS can own a write; completion is signalled with zero data.
                if (mem_ready && cmd_q.we) begin
                    ls_rvalid_d = 1'b1;
                    ls_rdata_d  = '0;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    if (owner_ls_q) begin
                        ls_rvalid_d = 1'b1;
                        ls_rdata_d  = mem_rdata;
                    end else begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = mem_rdata;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_q       <= '0;
            owner_ls_q  <= 1'b0;
            if_gnt_q    <= 1'b0;
            ls_gnt_q    <= 1'b0;
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
            proto_err_q <= 1'b0;
        end else begin
            cmd_q       <= cmd_d;
            owner_ls_q  <= owner_ls_d;
            if_gnt_q    <= if_gnt_d;
            ls_gnt_q    <= ls_gnt_d;
            if_rvalid_q <= if_rvalid_d;
            ls_rvalid_q <= ls_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            ls_rdata_q  <= ls_rdata_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign if_gnt    = if_gnt_q;
    assign ls_gnt    = ls_gnt_q;
    assign if_rvalid = if_rvalid_q;
    assign ls_rvalid = ls_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign ls_rdata  = ls_rdata_q;
    assign proto_err = proto_err_q;
    assign mem_we    = cmd_q.we;
    assign mem_addr  = cmd_q.addr;
    assign mem_wdata = cmd_q.wdata;
    assign mem_wstrb = cmd_q.wstrb;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random traffic for mem_port_arbiter checked cycle by cycle against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req, if_gnt, if_rvalid;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          ls_req, ls_we, ls_gnt, ls_rvalid;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata, ls_rdata;
    logic [SW-1:0] ls_wstrb;
    logic          mem_req, mem_we, mem_ready, mem_rvalid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [SW-1:0] mem_wstrb;
    logic          busy, proto_err;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_wstrb(ls_wstrb), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .busy(busy), .proto_err(proto_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Memory contents; untouched words read back as an address hash.
    logic [31:0] mem_m [logic [31:0]];
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_m.exists(a)) return mem_m[a];
        return a ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] rand_addr();
        return 32'h100 + ($urandom_range(0, 15) << 2);
    endfunction

    // Requesters: a pending transaction per port, held until granted.
    bit          if_pend, ls_pend, ls_w;
    logic [31:0] if_a, ls_a, ls_wd;
    logic [3:0]  ls_s;
    int          p_if, p_ls, p_rdy, p_stray, min_dly, max_dly;
    bit          do_reset, force_rv;

    // Transaction in flight and expected outputs for the next cycle.
    bit          inflight, accepted, own_ls, t_we, last_ls;
    logic [31:0] t_addr, t_wd;
    logic [3:0]  t_st;
    int          rv_wait;
    bit          e_if_gnt, e_ls_gnt, e_if_rv, e_ls_rv, e_busy, e_mreq, e_proto;
    logic [31:0] e_if_rd, e_ls_rd;

    task automatic cycle();
        bit pick_ls;
        logic [31:0] w;
        @(negedge clk);
        chk("if_gnt", if_gnt, e_if_gnt);
        chk("ls_gnt", ls_gnt, e_ls_gnt);
        chk("if_rvalid", if_rvalid, e_if_rv);
        chk("ls_rvalid", ls_rvalid, e_ls_rv);
        chk("if_rdata", if_rdata, e_if_rd);
        chk("ls_rdata", ls_rdata, e_ls_rd);
        chk("busy", busy, e_busy);
        chk("mem_req", mem_req, e_mreq);
        chk("proto_err", proto_err, e_proto);
        if (e_mreq) begin
            chk("mem_we", mem_we, t_we);
            chk("mem_addr", mem_addr, t_addr);
            chk("mem_wstrb", mem_wstrb, t_st);
            if (t_we) chk("mem_wdata", mem_wdata, t_wd);
        end

        // Drive inputs for this cycle
        if (!if_pend && ($urandom % 100) < p_if) begin
            if_pend = 1; if_a = rand_addr();
        end
        if (!ls_pend && ($urandom % 100) < p_ls) begin
            ls_pend = 1; ls_w = $urandom_range(0, 1); ls_a = rand_addr();
            ls_wd = $urandom; ls_s = 4'($urandom_range(1, 15));
        end
        reset    = do_reset;
        if_req   = if_pend;
        if_addr  = if_pend ? if_a : $urandom;
        ls_req   = ls_pend;
        ls_we    = ls_pend ? ls_w : 1'($urandom);
        ls_addr  = ls_pend ? ls_a : $urandom;
        ls_wdata = ls_pend ? ls_wd : $urandom;
        ls_wstrb = ls_pend ? ls_s : 4'($urandom);
        mem_ready  = ($urandom % 100) < p_rdy;
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        if (inflight && accepted && !t_we) begin
            if (rv_wait == 0) begin
                mem_rvalid = 1'b1; mem_rdata = mem_rd(t_addr);
            end else rv_wait--;
        end else if (force_rv || ($urandom % 100) < p_stray) begin
            mem_rvalid = 1'b1;
        end

        // Effect of the coming clock edge
        e_if_gnt = 0; e_ls_gnt = 0; e_if_rv = 0; e_ls_rv = 0;
        if (do_reset) begin
            inflight = 0; accepted = 0; last_ls = 0; e_proto = 0;
            e_if_rd = '0; e_ls_rd = '0; if_pend = 0; ls_pend = 0;
        end else begin
            if (mem_rvalid && !(inflight && accepted && !t_we)) e_proto = 1;
            if (!inflight) begin
                if (if_pend || ls_pend) begin
`ifdef ARB_RR_EN
                    pick_ls = ls_pend && (!if_pend || !last_ls);
`else
                    pick_ls = ls_pend;
`endif
                    last_ls = pick_ls; inflight = 1; accepted = 0; own_ls = pick_ls;
                    if (pick_ls) begin
                        t_we = ls_w; t_addr = ls_a; t_wd = ls_wd;
                        t_st = ls_w ? ls_s : 4'h0; ls_pend = 0; e_ls_gnt = 1;
                    end else begin
                        t_we = 0; t_addr = if_a; t_wd = '0; t_st = 4'h0;
                        if_pend = 0; e_if_gnt = 1;
                    end
                end
            end else if (!accepted) begin
                if (mem_ready) begin
                    accepted = 1;
                    if (t_we) begin
                        w = mem_rd(t_addr);
                        for (int b = 0; b < 4; b++) if (t_st[b]) w[8*b +: 8] = t_wd[8*b +: 8];
                        mem_m[t_addr] = w;
                        inflight = 0; e_ls_rv = 1; e_ls_rd = '0;
                    end else begin
                        rv_wait = $urandom_range(min_dly, max_dly);
                    end
                end
            end else if (mem_rvalid) begin
                inflight = 0;
                if (own_ls) begin e_ls_rv = 1; e_ls_rd = mem_rdata; end
                else        begin e_if_rv = 1; e_if_rd = mem_rdata; end
            end
        end
        e_busy = inflight;
        e_mreq = inflight && !accepted;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic set_traffic(input int pi, input int pl, input int pr, input int mn, input int mx);
        p_if = pi; p_ls = pl; p_rdy = pr; min_dly = mn; max_dly = mx;
    endtask

    initial begin
        reset = 1; if_req = 0; if_addr = '0; ls_req = 0; ls_we = 0; ls_addr = '0;
        ls_wdata = '0; ls_wstrb = '0; mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
        if_pend = 0; ls_pend = 0; inflight = 0; accepted = 0; last_ls = 0; own_ls = 0;
        t_we = 0; t_addr = '0; t_wd = '0; t_st = '0; rv_wait = 0;
        e_if_gnt = 0; e_ls_gnt = 0; e_if_rv = 0; e_ls_rv = 0; e_busy = 0; e_mreq = 0;
        e_proto = 0; e_if_rd = '0; e_ls_rd = '0; p_stray = 0; force_rv = 0;
        set_traffic(0, 0, 100, 0, 0);
        do_reset = 1;
        repeat (2) @(negedge clk);
        run(2);
        do_reset = 0;

        // IF read of 0x10 with a fast memory
        mem_m[32'h10] = 32'h0050_0093;
        if_pend = 1; if_a = 32'h10;
        run(6);

        // LS load and IF fetch arrive together
        ls_pend = 1; ls_w = 0; ls_a = 32'h100; ls_wd = '0; ls_s = 4'h0;
        if_pend = 1; if_a = 32'h104;
        run(10);

        // Store to a memory that stalls three cycles, then read it back
        ls_pend = 1; ls_w = 1; ls_a = 32'h200; ls_wd = 32'hDEAD_BEEF; ls_s = 4'hF;
        set_traffic(0, 0, 0, 0, 0);
        run(4);
        set_traffic(0, 0, 100, 0, 0);
        run(4);
        ls_pend = 1; ls_w = 0; ls_a = 32'h200;
        run(6);

        // Both ports requesting continuously
        set_traffic(100, 100, 100, 0, 0);
        run(24);

        // Mixed random traffic, slow and variable memory
        set_traffic(30, 30, 60, 0, 3);
        run(3000);

        // Stray rvalid while idle, sticky through traffic, cleared by reset
        set_traffic(0, 0, 100, 0, 0);
        run(20);
        force_rv = 1; run(1); force_rv = 0;
        set_traffic(30, 30, 70, 0, 2);
        run(200);
        set_traffic(0, 0, 100, 0, 0);
        run(20);
        do_reset = 1; run(1); do_reset = 0;
        run(3);

        // Reset while waiting for read data, then the late rvalid arrives
        if_pend = 1; if_a = 32'h40;
        set_traffic(0, 0, 100, 6, 6);
        for (int i = 0; i < 20 && !(inflight && accepted); i++) cycle();
        chk("reach_wait", inflight && accepted, 1'b1);
        do_reset = 1; run(1); do_reset = 0;
        force_rv = 1; run(1); force_rv = 0;
        run(5);

        // More random traffic after recovery
        set_traffic(40, 40, 50, 0, 2);
        run(1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
